// File: rtl/bike_light_mode_ctrl_pkg.sv
// Mode encodings shared by the bike light sequencer, lamp driver and benches.
package bike_light_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_STEADY     = 2'd1,
        MODE_BLINK_SLOW = 2'd2,
        MODE_BLINK_FAST = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:        return MODE_STEADY;
            MODE_STEADY:     return MODE_BLINK_SLOW;
            MODE_BLINK_SLOW: return MODE_BLINK_FAST;
            default:         return MODE_OFF;
        endcase
    endfunction

    function automatic logic is_blink(input mode_t m);
        return (m == MODE_BLINK_SLOW) || (m == MODE_BLINK_FAST);
    endfunction

endpackage

// File: rtl/bike_light_mode_ctrl_if.sv
// Board-side pins of the bike light: raw switches in, lamp drive and status out.
interface bike_light_mode_ctrl_if;
    import bike_light_pkg::*;

    logic  btn;
    logic  brake;
    logic  out;
    mode_t mode;
    logic  held;

    modport master (output btn, brake, input out, mode, held);
    modport slave  (input btn, brake, output out, mode, held);
endinterface

// File: rtl/bike_light_mode_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; held flips only after
// the synchronised input has differed from it for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic held_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          held_q, held_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = '0;
        held_d = held_q;
        if (sync2_q != held_q) begin
            if (cnt_q == CNT_MAX - 1'b1) begin
                held_d = ~held_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    assign held_o = held_q;
endmodule

// File: rtl/bike_light_mode_ctrl.sv
// Bike light sequencer. Modes: OFF lamp dark | STEADY lamp on | BLINK_SLOW/FAST
// lamp follows blink phase. Short press advances, long press forces OFF, brake lights lamp.
module bike_light_mode_ctrl
    import bike_light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_PRESS      = 200_000_000,
    parameter int SLOW_HALF       = 25_000_000,
    parameter int FAST_HALF       = 6_250_000
) (
    input logic                   clk,
    input logic                   reset,
    bike_light_mode_ctrl_if.slave bus
);
    localparam int HW = $clog2(LONG_PRESS + 1);
    localparam int BW = $clog2(SLOW_HALF + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS);
    localparam logic [BW-1:0] SLOW_MAX = BW'(SLOW_HALF - 1);
    localparam logic [BW-1:0] FAST_MAX = BW'(FAST_HALF - 1);

    logic          held;
    logic          brake_s1_q, brake_s2_q;
    logic          held_prev_q;
    logic [HW-1:0] hold_q, hold_d;
    logic          lp_latch_q, lp_latch_d;
    mode_t         mode_q, mode_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          out_q, out_d;
    logic          long_hit, fall;
    logic [BW-1:0] half_max;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (bus.btn),
        .held_o (held)
    );

    always_comb begin
        hold_d = '0;
        if (held) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
        long_hit = held && (hold_q == HOLD_MAX - 1'b1);
        fall     = held_prev_q && !held;

        mode_d     = mode_q;
        lp_latch_d = lp_latch_q;
        if (long_hit) begin
            mode_d     = MODE_OFF;
            lp_latch_d = 1'b1;
        end else if (fall) begin
            // The release that ends a long press only re-arms short presses.
            if (lp_latch_q) begin
                lp_latch_d = 1'b0;
            end else begin
                mode_d = next_mode(mode_q);
            end
        end

        half_max = (mode_q == MODE_BLINK_FAST) ? FAST_MAX : SLOW_MAX;
        blink_d  = '0;
        phase_d  = 1'b0;
        if (mode_d != mode_q) begin
            phase_d = is_blink(mode_d);
        end else if (is_blink(mode_q)) begin
            if (blink_q == half_max) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
                phase_d = phase_q;
            end
        end

        out_d = brake_s2_q || (mode_q == MODE_STEADY) || (is_blink(mode_q) && phase_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brake_s1_q  <= 1'b0;
            brake_s2_q  <= 1'b0;
            held_prev_q <= 1'b0;
            hold_q      <= '0;
            lp_latch_q  <= 1'b0;
            mode_q      <= MODE_OFF;
            blink_q     <= '0;
            phase_q     <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            brake_s1_q  <= bus.brake;
            brake_s2_q  <= brake_s1_q;
            held_prev_q <= held;
            hold_q      <= hold_d;
            lp_latch_q  <= lp_latch_d;
            mode_q      <= mode_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            out_q       <= out_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.mode = mode_q;
    assign bus.held = held;
endmodule

// File: tb/tb_bike_light_mode_ctrl.sv
// Bench for bike_light_mode_ctrl: expected outputs are queued with a due cycle
// when stimulus is applied and compared when that cycle's outputs are valid.
module tb_bike_light_mode_ctrl;
    import bike_light_pkg::*;

    localparam logic [2:0] CK_MODE = 3'b100;
    localparam logic [2:0] CK_OUT  = 3'b010;
    localparam logic [2:0] CK_HELD = 3'b001;
    localparam logic [2:0] CK_ALL  = 3'b111;

    typedef struct {
        int         due;
        string      name;
        logic [2:0] mask;
        logic [1:0] mode;
        logic       out;
        logic       held;
    } exp_t;

    typedef struct {
        int         len;
        logic [1:0] mode_before;
        logic [1:0] mode_after;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[6];

    bike_light_mode_ctrl_if bl_if ();

    bike_light_mode_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .LONG_PRESS      (20),
        .SLOW_HALF       (8),
        .FAST_HALF       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bl_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input string name, input logic [2:0] mask,
                             input logic [1:0] m, input logic o, input logic h);
        exp_t e;
        e.due  = cyc + dly;
        e.name = name;
        e.mask = mask;
        e.mode = m;
        e.out  = o;
        e.held = h;
        sb.push_back(e);
    endtask

    task automatic short_press();
        bl_if.btn = 1'b1;
        step(10);
        bl_if.btn = 1'b0;
        step(12);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                exp_t e;
                logic ok;
                e  = sb[i];
                ok = 1'b1;
                if (e.mask[2] && (2'(bl_if.mode) !== e.mode)) ok = 1'b0;
                if (e.mask[1] && (bl_if.out !== e.out)) ok = 1'b0;
                if (e.mask[0] && (bl_if.held !== e.held)) ok = 1'b0;
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got mode=%0d out=%b held=%b, required mode=%0d out=%b held=%b (checked %b)",
                             e.name, cyc, 2'(bl_if.mode), bl_if.out, bl_if.held,
                             e.mode, e.out, e.held, e.mask);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        vecs[0] = '{len: 10, mode_before: 2'd0, mode_after: 2'd1};
        vecs[1] = '{len: 10, mode_before: 2'd1, mode_after: 2'd2};
        vecs[2] = '{len: 10, mode_before: 2'd2, mode_after: 2'd3};
        vecs[3] = '{len: 10, mode_before: 2'd3, mode_after: 2'd0};
        vecs[4] = '{len: 3,  mode_before: 2'd0, mode_after: 2'd0};
        vecs[5] = '{len: 4,  mode_before: 2'd0, mode_after: 2'd1};

        reset       = 1'b1;
        bl_if.btn   = 1'b0;
        bl_if.brake = 1'b0;

        // Reset held for two edges
        @(posedge clk);
        #1;
        expect_at(0, "reset_edge1", CK_ALL, 2'd0, 1'b0, 1'b0);
        expect_at(1, "reset_edge2", CK_ALL, 2'd0, 1'b0, 1'b0);
        step(1);
        reset = 1'b0;
        step(2);

        n_tests++;
        if (2'(bl_if.mode) !== 2'd0) begin
            n_fail++;
            $display("FAIL post_reset_mode @cyc %0d: got mode=%0d, required 0", cyc, 2'(bl_if.mode));
        end
        n_tests++;
        if (bl_if.out !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_out @cyc %0d: got out=%b, required 0", cyc, bl_if.out);
        end
        n_tests++;
        if (bl_if.held !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_held @cyc %0d: got held=%b, required 0", cyc, bl_if.held);
        end

        // Table: short presses, wrap, glitch reject, minimum press
        foreach (vecs[i]) begin
            expect_at(6, "press_held", CK_HELD, 2'd0, 1'b0, (vecs[i].len >= 4));
            expect_at(vecs[i].len + 6, "press_mode_before", CK_MODE, vecs[i].mode_before, 1'b0, 1'b0);
            expect_at(vecs[i].len + 7, "press_mode_after", CK_MODE, vecs[i].mode_after, 1'b0, 1'b0);
            expect_at(vecs[i].len + 8, "press_out", CK_OUT, 2'd0, (vecs[i].mode_after != 2'd0), 1'b0);
            bl_if.btn = 1'b1;
            step(vecs[i].len);
            bl_if.btn = 1'b0;
            step(14);
        end

        // Blink cadence, slow: mode changes 17 cycles after press start
        expect_at(17, "slow_mode", CK_MODE, 2'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 32; k++)
            expect_at(17 + k, "slow_cadence", CK_OUT, 2'd0, (((k - 1) / 8) % 2 == 0), 1'b0);
        bl_if.btn = 1'b1;
        step(10);
        bl_if.btn = 1'b0;
        step(40);

        // Blink cadence, fast
        expect_at(17, "fast_mode", CK_MODE, 2'd3, 1'b0, 1'b0);
        for (int k = 1; k <= 18; k++)
            expect_at(17 + k, "fast_cadence", CK_OUT, 2'd0, (((k - 1) / 3) % 2 == 0), 1'b0);
        bl_if.btn = 1'b1;
        step(10);
        bl_if.btn = 1'b0;
        step(26);

        // Reset in the middle of BLINK_FAST
        reset = 1'b1;
        expect_at(1, "mid_reset", CK_ALL, 2'd0, 1'b0, 1'b0);
        step(1);
        reset = 1'b0;
        step(2);

        n_tests++;
        if (2'(bl_if.mode) !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset_mode @cyc %0d: got mode=%0d, required 0", cyc, 2'(bl_if.mode));
        end
        n_tests++;
        if (bl_if.out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_out @cyc %0d: got out=%b, required 0", cyc, bl_if.out);
        end
        n_tests++;
        if (bl_if.held !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_held @cyc %0d: got held=%b, required 0", cyc, bl_if.held);
        end

        // Long press from BLINK_SLOW
        short_press();
        short_press();
        expect_at(25, "lp_before_threshold", CK_MODE, 2'd2, 1'b0, 1'b0);
        expect_at(26, "lp_threshold", CK_MODE, 2'd0, 1'b0, 1'b0);
        expect_at(27, "lp_out_off", CK_OUT, 2'd0, 1'b0, 1'b0);
        expect_at(30, "lp_still_held", CK_MODE | CK_HELD, 2'd0, 1'b0, 1'b1);
        expect_at(36, "lp_release", CK_MODE | CK_HELD, 2'd0, 1'b0, 1'b0);
        expect_at(40, "lp_no_advance", CK_MODE, 2'd0, 1'b0, 1'b0);
        bl_if.btn = 1'b1;
        step(30);
        bl_if.btn = 1'b0;
        step(16);

        // Brake in OFF
        expect_at(2, "brake_off_sync", CK_OUT, 2'd0, 1'b0, 1'b0);
        expect_at(3, "brake_off_on", CK_MODE | CK_OUT, 2'd0, 1'b1, 1'b0);
        bl_if.brake = 1'b1;
        step(5);
        expect_at(2, "brake_off_hold", CK_OUT, 2'd0, 1'b1, 1'b0);
        expect_at(3, "brake_off_release", CK_MODE | CK_OUT, 2'd0, 1'b0, 1'b0);
        bl_if.brake = 1'b0;
        step(6);

        // Short press after a long press advances again
        expect_at(16, "post_lp_before", CK_MODE, 2'd0, 1'b0, 1'b0);
        expect_at(17, "post_lp_press", CK_MODE, 2'd1, 1'b0, 1'b0);
        short_press();

        // Brake during BLINK_SLOW: cadence continues underneath
        expect_at(17, "brake_slow_mode", CK_MODE, 2'd2, 1'b0, 1'b0);
        expect_at(37, "brake_slow_mode_hold", CK_MODE, 2'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++)
            expect_at(17 + k, "brake_slow_out", CK_OUT, 2'd0,
                      ((k >= 8 && k <= 27) ? 1'b1 : (((k - 1) / 8) % 2 == 0)), 1'b0);
        short_press();
        bl_if.brake = 1'b1;
        step(20);
        bl_if.brake = 1'b0;
        step(20);

        step(5);
        m = sb.size();
        for (int i = 0; i < m; i++) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, due cycle %0d, now %0d", sb[i].name, sb[i].due, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
